// File: rtl/bobc_pkg.sv
// Shared encodings for the BOBC datapath and its controller.
// Mux selects, ALU op codes and multiplier sequencer states.
package bobc_pkg;

    localparam logic [1:0] M0_ZERO = 2'b00;
    localparam logic [1:0] M0_X    = 2'b01;
    localparam logic [1:0] M0_H    = 2'b10;
    localparam logic [1:0] M0_S    = 2'b11;

    localparam logic [1:0] M1_A    = 2'b00;
    localparam logic [1:0] M1_B    = 2'b01;
    localparam logic [1:0] M1_C    = 2'b10;
    localparam logic [1:0] M1_ZERO = 2'b11;

    localparam logic [1:0] M2_COEF = 2'b00;
    localparam logic [1:0] M2_ONE  = 2'b01;
    localparam logic [1:0] M2_H    = 2'b10;
    localparam logic [1:0] M2_X    = 2'b11;

    localparam logic H_MUL = 1'b0;
    localparam logic H_ADD = 1'b1;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_seq_bobc.sv
// Iterative shift-add multiplier with operand snapshot.
// Restarts whenever enabled operands differ from the snapshot; freezes when disabled.
module mul_seq_bobc
    import bobc_pkg::*;
#(
    parameter int W  = 8,
    parameter int PW = 2 * W
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    output logic [PW-1:0] prod,
    output logic          match,
    output logic          valid
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    mul_state_e    state_q, state_d;
    logic [W-1:0]  snap_a_q, snap_a_d;
    logic [W-1:0]  snap_b_q, snap_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] prod_q, prod_d;
    logic [PW-1:0] addend;

    // Snapshot compare and status outputs
    always_comb begin
        match = (state_q != MS_IDLE)
              && (a_in == snap_a_q)
              && (b_in == snap_b_q);
        valid = (state_q == MS_DONE);
        prod  = prod_q;
    end

    // Restart on operand change, otherwise one partial product per edge
    always_comb begin
        state_d  = state_q;
        snap_a_d = snap_a_q;
        snap_b_d = snap_b_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        addend   = PW'(snap_a_q) << cnt_q;
        if (en) begin
            if (!match) begin
                state_d  = MS_RUN;
                snap_a_d = a_in;
                snap_b_d = b_in;
                cnt_d    = '0;
                prod_d   = '0;
            end else begin
                unique case (state_q)
                    MS_RUN: begin
                        if (snap_b_q[cnt_q]) begin
                            prod_d = prod_q + addend;
                        end
                        if (cnt_q == CW'(W - 1)) begin
                            state_d = MS_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    MS_DONE: state_d = MS_DONE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Sequencer state registers
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= MS_IDLE;
            snap_a_q <= '0;
            snap_b_q <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/operativo_bobc.sv
// BOBC datapath: X/H/S registers, operand muxes, add/multiply ALU.
// Optional sticky overflow flag when BOBC_OVF_EN is defined.
module operativo_bobc
    import bobc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] coef_a,
    input  logic [W-1:0] coef_b,
    input  logic [W-1:0] coef_c,
    input  logic         lx,
    input  logic         lh,
    input  logic         ls,
    input  logic         h,
    input  logic [1:0]   m0,
    input  logic [1:0]   m1,
    input  logic [1:0]   m2,
    output logic         pronto,
    output logic [W-1:0] s_out
`ifdef BOBC_OVF_EN
    ,
    output logic         ovf
`endif
);

`ifdef BOBC_OVF_EN
    localparam int PW = 2 * W;
`else
    localparam int PW = W;
`endif

    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  hr_q, hr_d;
    logic [W-1:0]  s_q, s_d;
    logic [W-1:0]  op_a, op_b, coef;
    logic [W-1:0]  sum, res;
    logic [PW-1:0] prod;
    logic          mul_match, mul_valid;

    // Operand A and coefficient selection
    always_comb begin
        op_a = '0;
        unique case (m0)
            M0_ZERO: op_a = '0;
            M0_X:    op_a = x_q;
            M0_H:    op_a = hr_q;
            M0_S:    op_a = s_q;
            default: op_a = '0;
        endcase
        coef = '0;
        unique case (m1)
            M1_A:    coef = coef_a;
            M1_B:    coef = coef_b;
            M1_C:    coef = coef_c;
            M1_ZERO: coef = '0;
            default: coef = '0;
        endcase
    end

    // Operand B selection
    always_comb begin
        op_b = '0;
        unique case (m2)
            M2_COEF: op_b = coef;
            M2_ONE:  op_b = W'(1);
            M2_H:    op_b = hr_q;
            M2_X:    op_b = x_q;
            default: op_b = '0;
        endcase
    end

    mul_seq_bobc #(
        .W  (W),
        .PW (PW)
    ) u_mul (
        .ck    (ck),
        .rst   (rst),
        .en    (h == H_MUL),
        .a_in  (op_a),
        .b_in  (op_b),
        .prod  (prod),
        .match (mul_match),
        .valid (mul_valid)
    );

`ifdef BOBC_OVF_EN
    logic carry;
    logic res_ovf;
    logic ovf_q, ovf_d;

    // Adder with carry out and overflow of the selected result
    always_comb begin
        {carry, sum} = {1'b0, op_a} + {1'b0, op_b};
        res_ovf = (h == H_ADD) ? carry : (|prod[PW-1:W]);
    end

    // Sticky overflow: set on a result load, cleared by lx, set wins
    always_comb begin
        ovf_d = ovf_q;
        if ((lh || ls) && res_ovf) begin
            ovf_d = 1'b1;
        end else if (lx) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register
    always_ff @(posedge ck) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Truncating adder
    always_comb begin
        sum = op_a + op_b;
    end
`endif

    // Result mux and ready flag
    always_comb begin
        res    = (h == H_ADD) ? sum : prod[W-1:0];
        pronto = !rst && ((h == H_ADD) || (mul_match && mul_valid));
    end

    // Register loads; all use pre-edge values of res
    always_comb begin
        x_d  = lx ? x_in : x_q;
        hr_d = lh ? res  : hr_q;
        s_d  = ls ? res  : s_q;
    end

    // Datapath registers
    always_ff @(posedge ck) begin
        if (rst) begin
            x_q  <= '0;
            hr_q <= '0;
            s_q  <= '0;
        end else begin
            x_q  <= x_d;
            hr_q <= hr_d;
            s_q  <= s_d;
        end
    end

    assign s_out = s_q;

endmodule

// File: tb/tb_operativo_bobc.sv
// Testbench for operativo_bobc: directed steps then randomized segments.
// Reference model tracks registers and multiply latency in plain arithmetic.
module tb_operativo_bobc;

    localparam int W = 8;

    logic       ck = 1'b0;
    logic       rst;
    logic [7:0] x_in, coef_a, coef_b, coef_c;
    logic       lx, lh, ls, h;
    logic [1:0] m0, m1, m2;
    logic       pronto;
    logic [7:0] s_out;
`ifdef BOBC_OVF_EN
    logic       ovf;
`endif

    operativo_bobc #(.W(W)) dut (
        .ck     (ck),
        .rst    (rst),
        .x_in   (x_in),
        .coef_a (coef_a),
        .coef_b (coef_b),
        .coef_c (coef_c),
        .lx     (lx),
        .lh     (lh),
        .ls     (ls),
        .h      (h),
        .m0     (m0),
        .m1     (m1),
        .m2     (m2),
        .pronto (pronto),
        .s_out  (s_out)
`ifdef BOBC_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 ck = ~ck;

    int n_chk = 0;
    int n_fail = 0;

    int mx = 0, mh = 0, ms = 0;
    bit mov = 0;
    bit sv = 0;
    int sa = 0, sb = 0, rem = 0;
    logic last_pronto;

    function automatic int opa();
        case (m0)
            2'd0: return 0;
            2'd1: return mx;
            2'd2: return mh;
            default: return ms;
        endcase
    endfunction

    function automatic int coefv();
        case (m1)
            2'd0: return int'(coef_a);
            2'd1: return int'(coef_b);
            2'd2: return int'(coef_c);
            default: return 0;
        endcase
    endfunction

    function automatic int opb();
        case (m2)
            2'd0: return coefv();
            2'd1: return 1;
            2'd2: return mh;
            default: return mx;
        endcase
    endfunction

    function automatic bit mpronto();
        if (rst) return 1'b0;
        if (h) return 1'b1;
        return sv && (sa == opa()) && (sb == opb()) && (rem == 0);
    endfunction

    function automatic int mres();
        if (h) return (opa() + opb()) % 256;
        return (opa() * opb()) % 256;
    endfunction

    function automatic bit movf();
        if (h) return (opa() + opb()) > 255;
        return (opa() * opb()) > 255;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int a, b, r;
        bit o;
        #2;
        last_pronto = pronto;
        chk("pronto", pronto, mpronto());
        chk("s_out", s_out, ms);
`ifdef BOBC_OVF_EN
        chk("ovf", ovf, mov);
`endif
        if (rst) begin
            mx = 0; mh = 0; ms = 0; mov = 0;
            sv = 0; sa = 0; sb = 0; rem = 0;
        end else begin
            a = opa();
            b = opb();
            r = mres();
            o = movf();
            if (!h) begin
                if (!sv || a != sa || b != sb) begin
                    sv = 1; sa = a; sb = b; rem = W;
                end else if (rem > 0) begin
                    rem--;
                end
            end
            if ((lh || ls) && o) mov = 1;
            else if (lx) mov = 0;
            if (lx) mx = int'(x_in);
            if (lh) mh = r;
            if (ls) ms = r;
        end
        @(posedge ck);
        #1;
    endtask

    initial begin
        rst = 1; lx = 0; lh = 0; ls = 0; h = 1;
        m0 = 0; m1 = 0; m2 = 0;
        x_in = 0; coef_a = 0; coef_b = 0; coef_c = 0;
        @(posedge ck);
        #1;

        // 1: reset
        cyc();
        chk("t1_pronto_rst", last_pronto, 0);
        cyc();
        rst = 0;
        chk("t1_sout", s_out, 0);

        // 2: load X=5, add X+X, load H, expose H via S
        x_in = 5; lx = 1;
        cyc();
        lx = 0;
        m0 = 2'd1; m2 = 2'd3; h = 1; lh = 1;
        cyc();
        chk("t2_pronto", last_pronto, 1);
        lh = 0;
        m0 = 2'd2; m1 = 2'd3; m2 = 2'd0; ls = 1;
        cyc();
        ls = 0;
        chk("t2_h", s_out, 10);

        // 3: X*coef_b = 5*7
        m0 = 2'd1; m1 = 2'd1; m2 = 2'd0; coef_b = 7; h = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("t3_wait", last_pronto, 0);
        end
        ls = 1;
        cyc();
        ls = 0;
        chk("t3_ready", last_pronto, 1);
        chk("t3_s", s_out, 35);

        // 4: operand change mid-multiply
        m0 = 2'd0;
        cyc();
        m0 = 2'd1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t4_wait_a", last_pronto, 0);
        end
        coef_b = 3;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("t4_wait_b", last_pronto, 0);
        end
        ls = 1;
        cyc();
        ls = 0;
        chk("t4_ready", last_pronto, 1);
        chk("t4_s", s_out, 15);

        // 5: add overflow 200+100
        h = 1; m0 = 2'd0; m1 = 2'd0; m2 = 2'd0; coef_a = 100; lh = 1;
        cyc();
        lh = 0;
        x_in = 200; lx = 1;
        cyc();
        lx = 0;
        m0 = 2'd1; m2 = 2'd2; ls = 1;
        cyc();
        ls = 0;
        chk("t5_s", s_out, 44);
`ifdef BOBC_OVF_EN
        chk("t5_ovf_set", ovf, 1);
        cyc();
        chk("t5_ovf_hold", ovf, 1);
        x_in = 1; lx = 1;
        cyc();
        lx = 0;
        chk("t5_ovf_clr", ovf, 0);
`endif

        // 6: reset mid-multiply
        h = 0; m0 = 2'd1; m1 = 2'd2; m2 = 2'd0; coef_c = 3;
        for (int i = 0; i < 5; i++) cyc();
        rst = 1;
        cyc();
        chk("t6_pronto_rst", last_pronto, 0);
        rst = 0;
        chk("t6_s", s_out, 0);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("t6_wait", last_pronto, 0);
        end
        cyc();
        chk("t6_ready", last_pronto, 1);

        // Randomized segments
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            bit do_rst;
            do_rst = ($urandom_range(0, 19) == 0);
            h = 1'($urandom);
            m0 = 2'($urandom);
            m1 = 2'($urandom);
            m2 = 2'($urandom);
            coef_a = 8'($urandom);
            coef_b = 8'($urandom);
            coef_c = 8'($urandom);
            x_in = 8'($urandom);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                rst = do_rst && (i == 0);
                lx = (i == 0) && 1'($urandom);
                lh = 0;
                ls = 0;
                if (i == len - 1 && mpronto()) begin
                    lh = 1'($urandom);
                    ls = 1'($urandom);
                end
                cyc();
            end
            rst = 0; lx = 0; lh = 0; ls = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
